// File: rtl/lane_gating_ctrl.sv
// rtl/lane_gating_ctrl.sv - idle-driven power gating controller for one functional-unit lane
// Gates the lane after a run of idle cycles and re-powers it on demand before accepting work.
module lane_gating_ctrl #(
   parameter int IdleCycles  = 16,
   parameter int WakeCycles  = 2,
   parameter int MaxInflight = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_valid_i,
   output logic req_ready_o,
   output logic fu_valid_o,
   input  logic fu_ready_i,
   input  logic fu_done_i,
   input  logic force_on_i,
   output logic gate_en_o,
   output logic gated_o
);
   localparam int InflW = $clog2(MaxInflight + 1);
   localparam int IdleW = (IdleCycles > 1) ? $clog2(IdleCycles) : 1;
   localparam int WakeW = (WakeCycles > 1) ? $clog2(WakeCycles) : 1;
   localparam logic [InflW-1:0] InflMax  = InflW'(MaxInflight);
   localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleCycles - 1);
   localparam logic [WakeW-1:0] WakeLast = WakeW'(WakeCycles - 1);

   typedef enum logic [1:0] { ST_ON, ST_GATED, ST_WAKE } state_t;

   state_t           state_q, state_d;
   logic [InflW-1:0] inflight_q, inflight_d;
   logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
   logic [WakeW-1:0] wake_cnt_q, wake_cnt_d;
   logic             gate_en_q, gated_q;
   logic             accept_allowed, accept, done_ok, idle;

   assign accept_allowed = (state_q == ST_ON) && (inflight_q < InflMax);
   assign fu_valid_o     = req_valid_i && accept_allowed;
   assign req_ready_o    = fu_ready_i && accept_allowed;
   assign accept         = req_valid_i && req_ready_o;
   // Retirements are only meaningful with work outstanding, which implies ON.
   assign done_ok        = fu_done_i && (inflight_q != '0) && (state_q == ST_ON);
   assign idle           = (state_q == ST_ON) && (inflight_q == '0) && !req_valid_i && !force_on_i;

   always_comb begin
      state_d    = state_q;
      inflight_d = inflight_q;
      idle_cnt_d = '0;
      wake_cnt_d = '0;
      if (accept && !done_ok) begin
         inflight_d = inflight_q + 1'b1;
      end else if (done_ok && !accept) begin
         inflight_d = inflight_q - 1'b1;
      end
      case (state_q)
         ST_ON: begin
            if (idle) begin
               if (idle_cnt_q == IdleLast) state_d = ST_GATED;
               else                        idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         ST_GATED: begin
            if (req_valid_i || force_on_i) state_d = ST_WAKE;
         end
         ST_WAKE: begin
            if (wake_cnt_q == WakeLast) state_d = ST_ON;
            else                        wake_cnt_d = wake_cnt_q + 1'b1;
         end
         default: state_d = ST_ON;
      endcase
   end

   // Enable and status are registered from the next state so they never glitch with inputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_ON;
         inflight_q <= '0;
         idle_cnt_q <= '0;
         wake_cnt_q <= '0;
         gate_en_q  <= 1'b1;
         gated_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         idle_cnt_q <= idle_cnt_d;
         wake_cnt_q <= wake_cnt_d;
         gate_en_q  <= (state_d != ST_GATED);
         gated_q    <= (state_d == ST_GATED);
      end
   end

   assign gate_en_o = gate_en_q;
   assign gated_o   = gated_q;

endmodule

// File: tb/tb_lane_gating_ctrl.sv
// tb/tb_lane_gating_ctrl.sv - self-checking bench for lane_gating_ctrl
module tb_lane_gating_ctrl;
   logic clk = 1'b0;
   logic rst, rv, ready, valid, fr, fd, fo, gate, gated;

   always #5 clk = ~clk;

   lane_gating_ctrl #(.IdleCycles(16), .WakeCycles(2), .MaxInflight(8)) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(rv), .req_ready_o(ready),
      .fu_valid_o(valid), .fu_ready_i(fr), .fu_done_i(fd), .force_on_i(fo),
      .gate_en_o(gate), .gated_o(gated)
   );

   typedef struct {
      logic rv, fr, fd, fo;
      logic ready, valid, gate, gated;
      string name;
   } vec_t;

   typedef struct {
      logic [3:0] outs;
      string      name;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic vec_t mk(input logic a_rv, a_fr, a_fd, a_fo,
                               input logic e_ready, e_valid, e_gate, e_gated,
                               input string name);
      vec_t v;
      v.rv = a_rv; v.fr = a_fr; v.fd = a_fd; v.fo = a_fo;
      v.ready = e_ready; v.valid = e_valid; v.gate = e_gate; v.gated = e_gated;
      v.name = name;
      return v;
   endfunction

   task automatic compare(input string name, input logic [3:0] act, input logic [3:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: ready/valid/gate_en/gated got %b required %b", name, act, req);
   endtask

   // Drive one cycle at posedge+1, sample at the following negedge, return at posedge+1.
   task automatic cyc(input vec_t v);
      exp_t e;
      rv = v.rv; fr = v.fr; fd = v.fd; fo = v.fo;
      e.outs = {v.ready, v.valid, v.gate, v.gated};
      e.name = v.name;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      compare(e.name, {ready, valid, gate, gated}, e.outs);
      @(posedge clk); #1;
   endtask

   // Idle cycles starting from idle-count 'first'; gating lands after the 16th idle cycle.
   task automatic idle_run(input int first, input logic ready_on, input string name);
      for (int i = first; i <= 16; i++)
         cyc(mk(1'b0, ready_on, 1'b0, 1'b0, ready_on && (i < 16), 1'b0, i < 16, i >= 16, name));
   endtask

   initial begin
      rst = 1'b1; rv = 1'b0; fr = 1'b0; fd = 1'b0; fo = 1'b0;
      #2;
      compare("reset_state", {ready, valid, gate, gated}, 4'b0010);
      @(posedge clk); #1;
      cyc(mk(1, 1, 0, 0, 1, 1, 1, 0, "rst_follow"));
      cyc(mk(1, 1, 0, 0, 1, 1, 1, 0, "rst_follow"));

      rst = 1'b0;
      idle_run(0, 1'b0, "idle_gate");
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, "gated_stay"));

      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, "gated_pending"));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, "wake1"));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, "wake2"));
      tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, "first_accept"));
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0, "done_one"));
      for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, "cap_fill"));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, "cap_full"));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, "cap_done"));
      tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, "cap_reopen"));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, "cap_done2"));
      tbl.push_back(mk(1, 1, 1, 0, 1, 1, 1, 0, "simul_acc_done"));
      tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, "after_simul"));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, "full_again"));
      for (int i = 0; i < 20; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, "no_gate_busy"));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, "drain_full"));
      for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0, "drain"));
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0, "underflow_done"));
      for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);
      idle_run(1, 1'b1, "idle_after_underflow");

      cyc(mk(0, 1, 0, 1, 0, 0, 0, 1, "force_pulse"));
      cyc(mk(0, 1, 0, 0, 0, 0, 1, 0, "force_wake1"));
      cyc(mk(0, 1, 0, 0, 0, 0, 1, 0, "force_wake2"));
      cyc(mk(0, 1, 0, 0, 1, 0, 1, 0, "force_wake_on"));
      for (int i = 0; i < 100; i++) cyc(mk(0, 0, 0, 1, 0, 0, 1, 0, "force_hold"));
      idle_run(0, 1'b0, "idle_after_force");

      cyc(mk(1, 1, 0, 0, 0, 0, 0, 1, "wake_req"));
      rv = 1'b1; fr = 1'b1;
      #1;
      compare("mid_wake", {ready, valid, gate, gated}, 4'b0010);
      #1 rst = 1'b1;
      #1;
      compare("rst_mid_wake", {ready, valid, gate, gated}, 4'b1110);
      @(posedge clk); #1;
      rst = 1'b0;
      idle_run(0, 1'b0, "idle_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
